sync_ram_clr: RTL and testbench
===============================

SYNC_RAM_CLR -- requirements
Module: sync_ram_clr

Interface
REQ-001 The block SHALL take parameter DATA_W, default 8, word width in bits.
REQ-002 The block SHALL take parameter ADDR_W, default 7, address width in bits.
REQ-003 The block SHALL take parameter DEPTH, default 128, number of words; legal range 2..2**ADDR_W.
REQ-004 The block SHALL take parameter RD_LAT, default 1, read latency in clock edges; legal values 1 or 2.
REQ-005 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port reset, input, 1, reset that is synchronous and active-low.
REQ-007 The block SHALL have port cs, input, 1, chip select.
REQ-008 The block SHALL have port we, input, 1, write enable.
REQ-009 The block SHALL have port oe, input, 1, read (output) enable.
REQ-010 The block SHALL have port address, input, ADDR_W, word address.
REQ-011 The block SHALL have port data_in, input, DATA_W, write data.
REQ-012 The block SHALL have port data_out, output, DATA_W, registered read data.
REQ-013 The block SHALL have port rd_valid, output, 1, one-cycle pulse marking new data_out.
REQ-014 The block SHALL have port busy, output, 1, high while the memory is being cleared.
REQ-015 The block SHALL have port err, output, 1, one-cycle pulse on a rejected or out-of-range request.

Function
REQ-016 The controller SHALL have two states:
- CLEAR: writes zero to one word per edge, clear pointer 0..DEPTH-1.
- IDLE: services requests.
REQ-017 CLEAR SHALL transition to IDLE on the edge that zeroes word DEPTH-1, so clear takes exactly DEPTH edges after reset release; busy SHALL be high throughout CLEAR.
REQ-018 In IDLE with cs=1, we=1, address<DEPTH, mem[address] SHALL take data_in at that edge.
REQ-019 In IDLE with cs=1, we=0, oe=1, a read SHALL be accepted:
- RD_LAT=1: data_out and rd_valid update at the accepting edge.
- RD_LAT=2: data_out and rd_valid update one edge later.
REQ-020 When cs=1, we=1 and oe=1 together, the write SHALL take priority and no read SHALL occur.
REQ-021 A read of an address written on the previous edge SHALL return the newly written data.
REQ-022 data_out SHALL hold its last value when no read completes.
REQ-023 rd_valid SHALL be high for exactly one cycle per accepted read; back-to-back reads SHALL give back-to-back pulses with no bubble.
REQ-024 Out-of-range requests (address>=DEPTH) SHALL be handled as follows:
- Write: dropped.
- Read: completes with data_out=0 and rd_valid=1.
- Both: err pulses, aligned to the accepting edge.
REQ-025 Any request with cs=1 and (we=1 or oe=1) during CLEAR SHALL be ignored (no write, no rd_valid) and SHALL pulse err.
REQ-026 Requests with cs=0 SHALL have no effect regardless of we and oe.

Reset
REQ-027 While reset=0 at an edge:
- data_out=0, rd_valid=0, err=0, busy=1.
- Clear pointer=0, state=CLEAR.
- Any read in the RD_LAT=2 pipeline is discarded.
REQ-028 Reset asserted mid-CLEAR SHALL restart clearing from word 0.
REQ-029 Reset asserted in IDLE SHALL restart clearing from word 0, discarding memory contents.
REQ-030 Memory contents SHALL NOT be reset directly; they are zeroed only by the CLEAR sequence.

Structure
REQ-031 Shared package ram_pkg SHALL hold:
- The state typedef (enum CLEAR, IDLE).
- Default values for DATA_W, ADDR_W, DEPTH and RD_LAT.
REQ-032 The optional second read stage SHALL be a sub-module ram_rd_pipe, parameterised on DATA_W, carrying data and valid, instantiated only when RD_LAT=2.
REQ-033 Storage SHALL be a single array of DEPTH words of DATA_W bits with one write port and one read port, inferable as block RAM.

Verification
REQ-034 Release reset, hold cs=1 oe=1 -> busy high for exactly 128 edges, err pulses each of those edges, no rd_valid; busy low afterwards.
REQ-035 After clear, write 8'hA5 to address 5, then read address 5 on the next cycle -> data_out=8'hA5 with rd_valid on the read edge (RD_LAT=1) or one edge later (RD_LAT=2).
REQ-036 After clear, read address 17 without a prior write -> data_out=8'h00, rd_valid=1, err=0.
REQ-037 With DEPTH=100, write 8'h3C to address 120, then read address 120 -> write dropped, err pulses twice, read returns 8'h00 with rd_valid.
REQ-038 Assert cs=we=oe=1 with data_in=8'h5A at address 9 -> no rd_valid; a following read of address 9 returns 8'h5A.
REQ-039 Write 8'hFF to address 3, pulse reset low at clear pointer 60, release -> busy high 128 edges; a read of address 3 then returns 8'h00.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared types and parameter defaults for the clear-on-reset synchronous RAM.
package ram_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      IDLE  = 1'b1
   } state_t;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_ADDR_W = 7;
   localparam int DEF_DEPTH  = 128;
   localparam int DEF_RD_LAT = 1;

endpackage

// File: rtl/ram_rd_pipe.sv
// Optional second read stage: delays read data and valid by one edge.
module ram_rd_pipe #(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              vld_i,
   input  logic [DATA_W-1:0] data_i,
   output logic              vld_o,
   output logic [DATA_W-1:0] data_o
);

   logic              vld_q;
   logic [DATA_W-1:0] data_q;

   // data only moves with valid so the output holds between reads
   always_ff @(posedge clk) begin
      if (!reset) begin
         vld_q  <= 1'b0;
         data_q <= '0;
      end else begin
         vld_q <= vld_i;
         if (vld_i) begin
            data_q <= data_i;
         end
      end
   end

   assign vld_o  = vld_q;
   assign data_o = data_q;

endmodule

// File: rtl/sync_ram_clr.sv
// Single-port synchronous RAM that zeroes itself word-by-word after every reset.
//   state | meaning
//   CLEAR | writing zero at clr_ptr_q each edge; requests rejected with err
//   IDLE  | servicing reads and writes
module sync_ram_clr
   import ram_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DEPTH  = DEF_DEPTH,
   parameter int RD_LAT = DEF_RD_LAT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cs,
   input  logic              we,
   input  logic              oe,
   input  logic [ADDR_W-1:0] address,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   output logic              rd_valid,
   output logic              busy,
   output logic              err
);

   localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

   logic [DATA_W-1:0] mem [DEPTH];

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
   logic              err_q, err_d;
   logic              rd_vld_q;
   logic [DATA_W-1:0] rd_data_q;

   logic              in_range;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [DATA_W-1:0] mem_wdata;
   logic              rd_acc;

   assign in_range = ({1'b0, address} < DEPTH_C);

   always_comb begin
      state_d   = state_q;
      clr_ptr_d = clr_ptr_q;
      err_d     = 1'b0;
      mem_we    = 1'b0;
      mem_waddr = address;
      mem_wdata = data_in;
      rd_acc    = 1'b0;
      case (state_q)
         CLEAR: begin
            mem_we    = 1'b1;
            mem_waddr = clr_ptr_q;
            mem_wdata = '0;
            err_d     = cs & (we | oe);
            if (clr_ptr_q == LAST_PTR) begin
               state_d = IDLE;
            end else begin
               clr_ptr_d = clr_ptr_q + 1'b1;
            end
         end
         IDLE: begin
            // write wins over a simultaneous read request
            if (cs && we) begin
               if (in_range) begin
                  mem_we = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end else if (cs && oe) begin
               rd_acc = 1'b1;
               err_d  = ~in_range;
            end
         end
         default: begin
            state_d = CLEAR;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= CLEAR;
         clr_ptr_q <= '0;
         err_q     <= 1'b0;
         rd_vld_q  <= 1'b0;
         rd_data_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_ptr_q <= clr_ptr_d;
         err_q     <= err_d;
         rd_vld_q  <= rd_acc;
         if (rd_acc) begin
            rd_data_q <= in_range ? mem[address] : '0;
         end
      end
   end

   // storage has no reset; only the CLEAR walk zeroes it
   always_ff @(posedge clk) begin
      if (reset && mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

   generate
      if (RD_LAT == 2) begin : g_pipe
         ram_rd_pipe #(
            .DATA_W (DATA_W)
         ) u_rd_pipe (
            .clk    (clk),
            .reset  (reset),
            .vld_i  (rd_vld_q),
            .data_i (rd_data_q),
            .vld_o  (rd_valid),
            .data_o (data_out)
         );
      end else begin : g_direct
         assign rd_valid = rd_vld_q;
         assign data_out = rd_data_q;
      end
   endgenerate

   assign busy = (state_q == CLEAR);
   assign err  = err_q;

endmodule

// File: tb/tb_sync_ram_clr.sv
// Bench for sync_ram_clr: two instances (DEPTH=128/RD_LAT=1, DEPTH=100/RD_LAT=2) driven in lockstep.
module tb_sync_ram_clr;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset, cs, we, oe;
   logic [6:0] address;
   logic [7:0] data_in;
   logic [7:0] dout_a, dout_b;
   logic       vld_a, vld_b, busy_a, busy_b, err_a, err_b;

   sync_ram_clr #(.DATA_W(8), .ADDR_W(7), .DEPTH(128), .RD_LAT(1)) u_dut_a (
      .clk(clk), .reset(reset), .cs(cs), .we(we), .oe(oe), .address(address),
      .data_in(data_in), .data_out(dout_a), .rd_valid(vld_a), .busy(busy_a), .err(err_a)
   );

   sync_ram_clr #(.DATA_W(8), .ADDR_W(7), .DEPTH(100), .RD_LAT(2)) u_dut_b (
      .clk(clk), .reset(reset), .cs(cs), .we(we), .oe(oe), .address(address),
      .data_in(data_in), .data_out(dout_b), .rd_valid(vld_b), .busy(busy_b), .err(err_b)
   );

   typedef struct {
      logic [7:0] data;
      int         due;
   } rd_exp_t;

   rd_exp_t    q0[$];
   rd_exp_t    q1[$];
   int         n_chk = 0;
   int         n_pass = 0;
   int         cyc = 0;
   int         depth[2] = '{128, 100};
   int         lat[2]   = '{1, 2};
   logic [7:0] m_mem[2][128];
   logic       m_clr[2];
   int         m_ptr[2];
   logic       m_err[2];
   logic       m_busy[2];
   logic [7:0] m_dout[2];
   int         busy_cnt_a = 0;
   int         err_cnt_a = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
   endtask

   task automatic push_exp(input int i, input rd_exp_t ent);
      if (i == 0) q0.push_back(ent);
      else q1.push_back(ent);
   endtask

   // reference behaviour of instance i at the upcoming edge
   task automatic model_edge(input int i);
      int      e;
      rd_exp_t ent;
      e = cyc + 1;
      if (!reset) begin
         m_clr[i]  = 1'b1;
         m_ptr[i]  = 0;
         m_err[i]  = 1'b0;
         m_busy[i] = 1'b1;
         m_dout[i] = 8'h00;
         if (i == 0) while (q0.size() > 0 && q0[q0.size()-1].due >= e) void'(q0.pop_back());
         else        while (q1.size() > 0 && q1[q1.size()-1].due >= e) void'(q1.pop_back());
      end else if (m_clr[i]) begin
         m_mem[i][m_ptr[i]] = 8'h00;
         m_err[i] = cs && (we || oe);
         if (m_ptr[i] == depth[i] - 1) begin
            m_clr[i]  = 1'b0;
            m_busy[i] = 1'b0;
         end else begin
            m_ptr[i]++;
            m_busy[i] = 1'b1;
         end
      end else begin
         m_busy[i] = 1'b0;
         m_err[i]  = 1'b0;
         if (cs && we) begin
            if (int'(address) < depth[i]) m_mem[i][address] = data_in;
            else m_err[i] = 1'b1;
         end else if (cs && oe) begin
            if (int'(address) < depth[i]) ent.data = m_mem[i][address];
            else begin
               ent.data = 8'h00;
               m_err[i] = 1'b1;
            end
            ent.due = e + lat[i] - 1;
            push_exp(i, ent);
         end
      end
   endtask

   task automatic compare(input int i, input logic [7:0] dout, input logic vld,
                          input logic bsy, input logic er);
      logic    exp_vld;
      rd_exp_t ent;
      string   p;
      exp_vld = 1'b0;
      p = (i == 0) ? "a" : "b";
      if (i == 0 && q0.size() > 0 && q0[0].due == cyc) begin
         ent = q0.pop_front();
         exp_vld = 1'b1;
         m_dout[0] = ent.data;
      end else if (i == 1 && q1.size() > 0 && q1[0].due == cyc) begin
         ent = q1.pop_front();
         exp_vld = 1'b1;
         m_dout[1] = ent.data;
      end
      chk($sformatf("%s_rd_valid", p), 32'(vld), 32'(exp_vld));
      chk($sformatf("%s_data_out", p), 32'(dout), 32'(m_dout[i]));
      chk($sformatf("%s_busy", p), 32'(bsy), 32'(m_busy[i]));
      chk($sformatf("%s_err", p), 32'(er), 32'(m_err[i]));
   endtask

   task automatic cycle();
      logic r;
      r = reset;
      if (!r) begin
         busy_cnt_a = 0;
         err_cnt_a  = 0;
      end else if (busy_a) begin
         busy_cnt_a++;
      end
      model_edge(0);
      model_edge(1);
      @(posedge clk);
      #1;
      cyc++;
      if (r && err_a) err_cnt_a++;
      compare(0, dout_a, vld_a, busy_a, err_a);
      compare(1, dout_b, vld_b, busy_b, err_b);
   endtask

   task automatic drive(input logic r, input logic c, input logic w, input logic o,
                        input logic [6:0] a, input logic [7:0] d);
      reset   = r;
      cs      = c;
      we      = w;
      oe      = o;
      address = a;
      data_in = d;
   endtask

   initial begin
      drive(1'b0, 1'b1, 1'b0, 1'b1, 7'd0, 8'h00);
      repeat (3) cycle();

      // clear with a read held pending the whole time
      reset = 1'b1;
      repeat (128) cycle();
      chk("a_busy_edges", 32'(busy_cnt_a), 32'd128);
      chk("a_err_pulses", 32'(err_cnt_a), 32'd128);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 8'h00);
      repeat (3) cycle();

      // write then immediate read-back
      drive(1'b1, 1'b1, 1'b1, 1'b0, 7'd5, 8'hA5); cycle();
      drive(1'b1, 1'b1, 1'b0, 1'b1, 7'd5, 8'h00); cycle();
      drive(1'b1, 1'b1, 1'b0, 1'b1, 7'd17, 8'h00); cycle();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 8'h00); repeat (2) cycle();

      // address 120: in range for a, out of range for b
      drive(1'b1, 1'b1, 1'b1, 1'b0, 7'd120, 8'h3C); cycle();
      drive(1'b1, 1'b1, 1'b0, 1'b1, 7'd120, 8'h00); cycle();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 8'h00); repeat (2) cycle();

      // write beats read, cs=0 is inert
      drive(1'b1, 1'b1, 1'b1, 1'b1, 7'd9, 8'h5A); cycle();
      drive(1'b1, 1'b0, 1'b1, 1'b1, 7'd9, 8'h00); cycle();
      drive(1'b1, 1'b1, 1'b0, 1'b1, 7'd9, 8'h00); cycle();

      // back-to-back reads
      drive(1'b1, 1'b1, 1'b0, 1'b1, 7'd5, 8'h00);   cycle();
      drive(1'b1, 1'b1, 1'b0, 1'b1, 7'd120, 8'h00); cycle();
      drive(1'b1, 1'b1, 1'b0, 1'b1, 7'd9, 8'h00);   cycle();
      drive(1'b1, 1'b1, 1'b0, 1'b1, 7'd17, 8'h00);  cycle();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 8'h00);   repeat (3) cycle();

      for (int k = 0; k < 300; k++) begin
         drive(1'b1, ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
               ($urandom_range(0, 1) == 1), 7'($urandom_range(0, 127)), 8'($urandom));
         cycle();
      end

      // reset mid-clear restarts the walk and wipes earlier data
      drive(1'b1, 1'b1, 1'b1, 1'b0, 7'd3, 8'hFF); cycle();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 8'h00); cycle();
      reset = 1'b1;
      repeat (60) cycle();
      reset = 1'b0; cycle();
      reset = 1'b1;
      repeat (128) cycle();
      chk("a_busy_edges_restart", 32'(busy_cnt_a), 32'd128);
      drive(1'b1, 1'b1, 1'b0, 1'b1, 7'd3, 8'h00); cycle();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 8'h00); repeat (4) cycle();

      chk("a_pending_reads", 32'(q0.size()), 32'd0);
      chk("b_pending_reads", 32'(q1.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
